// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter: requester-index width
// derivation and the rotating-priority search used to pick the next owner.
package fifo_arb_pkg;

  // Widest requester vector the priority search handles.
  localparam int RR_MAX = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_result_t;

  // Requester-index width: clog2 of the requester count, never below one bit.
  function automatic int iw_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Circular find-first: scan req starting at index 'start', wrapping at n.
  // Equivalent to rotate-right by start, find lowest set bit, rotate back.
  function automatic rr_result_t rr_first(input logic [RR_MAX-1:0] req,
                                          input int n, input int start);
    rr_result_t r;
    int         k;
    r = '0;
    for (int i = 0; i < RR_MAX; i++) begin
      k = (start + i) % n;
      if ((i < n) && !r.found && req[k[3:0]]) begin
        r.found = 1'b1;
        r.idx   = k[3:0];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Given the request vector and the
// index with highest priority, returns the first requesting index at or after
// it (wrapping) and whether any request exists.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = iw_of(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_start,
  output logic [IW-1:0]   o_winner,
  output logic            o_found
);

  logic [RR_MAX-1:0] req_pad;
  rr_result_t        pick;

  assign req_pad  = RR_MAX'(i_req);
  assign pick     = rr_first(req_pad, NREQ, int'(i_start));
  assign o_found  = pick.found;
  assign o_winner = IW'(pick.idx);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one sfifo write port among NREQ
// valid/ready requesters. Each written entry is {source id, payload}.
// Optional feature macro FIFO_ARB_PKT_LOCK_EN: when defined, ownership is held
// until the owner's i_last beat (packet lock); when undefined, ownership is
// re-arbitrated on every transferred beat (beat-level interleave).
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int BW        = 8,
  parameter int LGFLEN    = 4,
  parameter int SPACE_MIN = 0,
  localparam int IW       = iw_of(NREQ)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NREQ-1:0]    i_valid,
  input  logic [NREQ*BW-1:0] i_data,
  input  logic [NREQ-1:0]    i_last,
  output logic [NREQ-1:0]    o_ready,
  output logic               o_fifo_wr,
  output logic [IW+BW-1:0]   o_fifo_data,
  input  logic               i_fifo_full,
  input  logic [LGFLEN:0]    i_fifo_fill,
  output logic [NREQ-1:0]    o_grant,
  output logic               o_busy
);

  localparam logic [LGFLEN:0] FIFO_DEPTH = (LGFLEN+1)'(2**LGFLEN);
  localparam logic [IW-1:0]   LAST_REQ   = IW'(NREQ-1);

  logic [IW-1:0]   last_id;
  logic [IW-1:0]   grant_id;
  logic [IW-1:0]   next_start;
  logic [IW-1:0]   winner;
  logic            found;
  logic [NREQ-1:0] xfer;
  logic            owner_done;
  logic            arb_event;
  logic [LGFLEN:0] fifo_free;
  logic            space_ok;

  // Handshake: only the owner sees ready, and only while the FIFO has room.
  assign o_ready   = o_grant & {NREQ{!i_fifo_full}};
  assign xfer      = i_valid & o_ready;
  assign o_fifo_wr = |xfer;
  assign o_busy    = |o_grant;

  // Encode the one-hot grant into the source id written with each beat.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (o_grant[k]) grant_id = IW'(k);
    end
  end

  // Idle grant_id is 0, so the bus shows requester 0's payload as don't-care.
  assign o_fifo_data = {grant_id, i_data[grant_id*BW +: BW]};

`ifdef FIFO_ARB_PKT_LOCK_EN
  // Ownership ends only on the owner's last beat of a packet.
  assign owner_done = |(xfer & i_last);
`else
  // Every transferred beat releases ownership; packet boundaries are ignored.
  logic unused_last;
  assign unused_last = ^i_last;
  assign owner_done  = o_fifo_wr;
`endif

  assign arb_event = !o_busy || owner_done;

  // Free entries in the downstream FIFO, computed at FIFO-count width.
  assign fifo_free = FIFO_DEPTH - i_fifo_fill;
  assign space_ok  = (SPACE_MIN == 0) || (int'(fifo_free) >= SPACE_MIN);

  // Search begins just past the last owner, making it lowest priority.
  assign next_start = (last_id == LAST_REQ) ? '0 : last_id + 1'b1;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_pick (
    .i_req    (i_valid),
    .i_start  (next_start),
    .o_winner (winner),
    .o_found  (found)
  );

  // Grant register: re-arbitrate when idle or when the owner finishes; the
  // space gate only blocks new grants, it never revokes a held one.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_grant <= '0;
      last_id <= LAST_REQ;
    end else if (arb_event) begin
      if (found && space_ok) begin
        o_grant <= NREQ'(1) << winner;
        last_id <= winner;
      end else begin
        o_grant <= '0;
      end
    end
  end

endmodule
